nn_sequencer: RTL and testbench
===============================

Name: nn_sequencer

Overview:
- Top-level controller for the two-layer inference datapath: sequenced hidden layer (multi-cycle, start/done) followed by parallel output layer (combinational, settles in fixed cycles).
- Accepts a start request, launches layer 1, waits for its completion, allows layer 2 to settle, then serially scans the OUT_SIZE IEEE-754 single-precision outputs for the argmax.
- Reports predicted class index and value with a done pulse; flags a layer-1 timeout.

Parameters:
- OUT_SIZE, 10, number of output-layer neurons (32-bit floats each); must be >= 1.
- IDX_W, 4, width of class index; must satisfy 2^IDX_W >= OUT_SIZE.
- L2_SETTLE, 2, cycles waited after l1_done before sampling layer-2 outputs; must be >= 1.
- L1_TIMEOUT, 20000, max cycles waited for l1_done after l1_start.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request one inference; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when result or error is valid.
- error  out  1  1 = layer-1 timeout for last run; held until next accepted start.
- l1_start  out  1  one-cycle launch pulse to layer 1.
- l1_done  in  1  layer-1 completion; level or pulse.
- l2_result  in  32*OUT_SIZE  layer-2 outputs; neuron i at bits [32*i +: 32].
- class_idx  out  IDX_W  argmax index; held until next accepted start.
- class_val  out  32  float value at class_idx; held likewise.

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; busy, done, error, l1_start = 0; class_idx = 0; class_val = 32'h0; all counters = 0. Reset mid-run aborts immediately. No done pulse is produced.
- States: IDLE, L1_RUN, L2_SETTLE, SCAN, FINISH.
- IDLE: on start=1, go to L1_RUN and clear error, class_idx and class_val. start=0 stays in IDLE.
- L1_RUN:
  - l1_start = 1 in the first cycle only; the timeout counter is cleared on entry.
  - l1_done is ignored in that first cycle and sampled from the following cycle onward.
  - l1_done=1 goes to L2_SETTLE.
  - If the counter reaches L1_TIMEOUT without l1_done: set error=1 and go to FINISH, skipping SCAN. l1_done and timeout in the same cycle: l1_done wins.
- L2_SETTLE: stay exactly L2_SETTLE cycles, then go to SCAN.
- SCAN:
  - Examine one element per cycle, i = 0..OUT_SIZE-1.
  - i=0 loads best := element 0, best_idx := 0.
  - For i>0, replace when element i is strictly greater than best, so ties keep the lower index.
  - After i = OUT_SIZE-1, write class_idx/class_val and go to FINISH.
- FINISH: done = 1 for this single cycle; next state IDLE.
- Float compare:
  - Both non-negative: unsigned magnitude compare.
  - Both negative: reversed magnitude compare.
  - Positive > negative.
  - +0 and -0 are equal.
  - NaN (exp=8'hFF, mantissa!=0) is smaller than any non-NaN. NaN vs NaN is not greater.
  - Infinities compare normally.
- Latency: l1_done first seen k cycles after l1_start (k>=1) gives done k + L2_SETTLE + OUT_SIZE + 1 cycles after l1_start. l1_start is asserted 1 cycle after the start edge.
- start while busy: ignored; no queuing.
- A new start may be accepted in the IDLE cycle immediately after FINISH.
- l2_result is only required stable during SCAN.

Test Plan:
- Basic inference, defaults:
  - l1_done pulses 5 cycles after l1_start; output 3 = 0x3F666666 (0.9), all others 0x3DCCCCCD (0.1).
  - Required: class_idx=3, class_val=0x3F666666, error=0.
  - done exactly 5+2+10+1=18 cycles after l1_start, width 1; busy high throughout.
- Tie and sign ordering:
  - Outputs 2 and 7 both 0x3F800000 (1.0); others mixed, including 0xBF800000 (-1.0) and 0x80000000 (-0).
  - Required: class_idx=2.
  - Separately, all negative with output 5 = 0xBDCCCCCD (-0.1), others -0.5: class_idx=5.
- NaN and zero handling:
  - Output 0 = 0x7FC00000 (NaN), output 1 = 0x80000000 (-0), rest 0xC0000000 (-2.0).
  - Required: class_idx=1.
  - All outputs +0/-0: class_idx=0.
- Timeout:
  - L1_TIMEOUT=50; l1_done never asserted.
  - Required: done ~51 cycles after l1_start, error=1, class_idx=0, class_val=0, no SCAN.
  - Next start clears error, and a normal run completes.
- Handshake corners:
  - start held high continuously: back-to-back runs, each with exactly one l1_start and one done; start pulses while busy have no effect.
  - l1_done held high from before start: not sampled in the l1_start cycle; advances on the next cycle.
- Reset mid-run:
  - rst_n=0 for one edge during SCAN.
  - Required: next cycle busy=0, done never pulses, outputs return to reset values.
  - The following start completes normally.

Source files
------------

// File: rtl/nn_sequencer_if.sv
// Handshake and data bundle between the inference sequencer and its
// surroundings: host request/result signals plus the layer-1/layer-2 datapath
// hooks. The sequencer takes the slave view; the host/datapath takes master.
interface nn_sequencer_if #(
    parameter int OUT_SIZE = 10,
    parameter int IDX_W    = 4
);
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    error;
    logic                    l1_start;
    logic                    l1_done;
    logic [32*OUT_SIZE-1:0]  l2_result;
    logic [IDX_W-1:0]        class_idx;
    logic [31:0]             class_val;

    modport slave (
        input  start, l1_done, l2_result,
        output busy, done, error, l1_start, class_idx, class_val
    );

    modport master (
        output start, l1_done, l2_result,
        input  busy, done, error, l1_start, class_idx, class_val
    );
endinterface

// File: rtl/nn_sequencer.sv
// Two-layer inference controller: launches layer 1, waits for completion or
// timeout, lets layer 2 settle, then scans the float outputs one per cycle for
// the argmax and reports it with a single-cycle done pulse.
module nn_sequencer #(
    parameter int OUT_SIZE   = 10,
    parameter int IDX_W      = 4,
    parameter int L2_SETTLE  = 2,
    parameter int L1_TIMEOUT = 20000
) (
    input  logic           clk,
    input  logic           rst_n,
    nn_sequencer_if.slave  bus
);
    localparam int WAIT_MAX = (L1_TIMEOUT > L2_SETTLE) ? L1_TIMEOUT : L2_SETTLE;
    localparam int CNT_W    = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_L1_RUN, S_L2_SETTLE, S_SCAN, S_FINISH
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   scan_idx;
    logic [IDX_W-1:0]   best_idx;
    logic [31:0]        best_val;
    logic               l1_start_q;
    logic               error_q;
    logic [IDX_W-1:0]   class_idx_q;
    logic [31:0]        class_val_q;
    logic [31:0]        elem;
    logic               take;
    logic               scan_last;
    logic [IDX_W-1:0]   new_idx;
    logic [31:0]        new_best;

    // True when a > b under IEEE-754 ordering with NaN ranked below everything
    // and +0 equal to -0.
    function automatic logic float_gt(input logic [31:0] a, input logic [31:0] b);
        logic a_nan;
        logic b_nan;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        if (a_nan) return 1'b0;
        if (b_nan) return 1'b1;
        if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) return 1'b0;
        if (a[31] != b[31]) return b[31];
        if (!a[31]) return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    // Current scan element and the running-best update it produces.
    always_comb begin
        elem      = bus.l2_result[{scan_idx, 5'b0} +: 32];
        scan_last = (scan_idx == IDX_W'(OUT_SIZE - 1));
        take      = (scan_idx == '0) || float_gt(elem, best_val);
        new_best  = take ? elem : best_val;
        new_idx   = take ? scan_idx : best_idx;
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all clocked state, so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state decode and status outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned and no latch is inferred.
        state_next = state;
        bus.busy   = (state != S_IDLE);
        bus.done   = (state == S_FINISH);
        case (state)
            S_IDLE:      if (bus.start) state_next = S_L1_RUN;
            // l1_done is ignored while the launch pulse is still high.
            S_L1_RUN:    if (!l1_start_q && bus.l1_done)         state_next = S_L2_SETTLE;
                         else if (cnt == CNT_W'(L1_TIMEOUT))     state_next = S_FINISH;
            S_L2_SETTLE: if (cnt == CNT_W'(L2_SETTLE - 1))      state_next = S_SCAN;
            S_SCAN:      if (scan_last)                          state_next = S_FINISH;
            S_FINISH:    state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // Counters, running best, launch pulse and held result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            scan_idx    <= '0;
            best_idx    <= '0;
            best_val    <= 32'h0;
            l1_start_q  <= 1'b0;
            error_q     <= 1'b0;
            class_idx_q <= '0;
            class_val_q <= 32'h0;
        end else begin
            l1_start_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        l1_start_q  <= 1'b1;
                        cnt         <= '0;
                        error_q     <= 1'b0;
                        class_idx_q <= '0;
                        class_val_q <= 32'h0;
                    end
                end
                S_L1_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (state_next == S_L2_SETTLE) cnt     <= '0;
                    else if (state_next == S_FINISH) error_q <= 1'b1;
                end
                S_L2_SETTLE: begin
                    cnt <= cnt + 1'b1;
                    if (state_next == S_SCAN) begin
                        cnt      <= '0;
                        scan_idx <= '0;
                    end
                end
                S_SCAN: begin
                    best_val <= new_best;
                    best_idx <= new_idx;
                    scan_idx <= scan_idx + 1'b1;
                    if (scan_last) begin
                        class_idx_q <= new_idx;
                        class_val_q <= new_best;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.l1_start  = l1_start_q;
    assign bus.error     = error_q;
    assign bus.class_idx = class_idx_q;
    assign bus.class_val = class_val_q;
endmodule

// File: tb/tb_nn_sequencer.sv
// Directed bench for nn_sequencer: latency, argmax ordering corner cases,
// layer-1 timeout, handshake corners and mid-run reset.
module tb_nn_sequencer;
    localparam int OUT_SIZE = 10;
    localparam int IDX_W    = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   passed = 0;
    int   total  = 0;

    nn_sequencer_if #(.OUT_SIZE(OUT_SIZE), .IDX_W(IDX_W)) bus ();

    nn_sequencer #(
        .OUT_SIZE(OUT_SIZE), .IDX_W(IDX_W), .L2_SETTLE(2), .L1_TIMEOUT(50)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < OUT_SIZE; i++) bus.l2_result[32*i +: 32] = v;
    endtask

    task automatic set_out(input int i, input logic [31:0] v);
        bus.l2_result[32*i +: 32] = v;
    endtask

    // Issues one start and follows the run until done (bounded). k is the
    // cycle after l1_start on which l1_done pulses (-1: never); hold leaves
    // l1_done as the caller set it. Returns in the done cycle.
    task automatic run(input int k, input bit hold, output int lat,
                       output int l1_cnt, output bit busy_ok);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = -1; l1_cnt = 0; busy_ok = 1'b1;
        for (int j = 0; j < 300; j++) begin
            if (!hold) bus.l1_done = (j == k);
            if (bus.l1_start) l1_cnt++;
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.done) begin lat = j; break; end
            tick();
        end
        bus.l1_done = 1'b0;
    endtask

    task automatic expect_result(input string name, input int lat, input int lat_exp,
                                 input logic [IDX_W-1:0] idx_exp, input logic [31:0] val_exp);
        total++; if (lat != lat_exp) $display("FAIL %s_latency: got %0d expected %0d", name, lat, lat_exp); else passed++;
        total++; if (bus.class_idx !== idx_exp) $display("FAIL %s_idx: got %0d expected %0d", name, bus.class_idx, idx_exp); else passed++;
        total++; if (bus.class_val !== val_exp) $display("FAIL %s_val: got %h expected %h", name, bus.class_val, val_exp); else passed++;
    endtask

    task automatic test_reset();
        total++; if ({bus.busy, bus.done, bus.error, bus.l1_start} !== 4'b0000)
            $display("FAIL reset_ctrl: got %b expected 0000", {bus.busy, bus.done, bus.error, bus.l1_start}); else passed++;
        total++; if (bus.class_idx !== 4'd0) $display("FAIL reset_idx: got %0d expected 0", bus.class_idx); else passed++;
        total++; if (bus.class_val !== 32'h0) $display("FAIL reset_val: got %h expected 0", bus.class_val); else passed++;
    endtask

    task automatic test_basic();
        int lat, l1c; bit bok;
        fill(32'h3DCCCCCD);
        set_out(3, 32'h3F666666);
        run(5, 1'b0, lat, l1c, bok);
        expect_result("basic", lat, 18, 4'd3, 32'h3F666666);
        total++; if (bus.error !== 1'b0) $display("FAIL basic_error: got %b expected 0", bus.error); else passed++;
        total++; if (l1c != 1) $display("FAIL basic_l1_start_count: got %0d expected 1", l1c); else passed++;
        total++; if (bok !== 1'b1) $display("FAIL basic_busy: got %b expected 1", bok); else passed++;
        tick();
        total++; if ({bus.done, bus.busy} !== 2'b00) $display("FAIL basic_after_done: got %b expected 00", {bus.done, bus.busy}); else passed++;
        repeat (3) tick();
        total++; if (bus.class_idx !== 4'd3) $display("FAIL basic_hold_idx: got %0d expected 3", bus.class_idx); else passed++;
    endtask

    task automatic test_tie_sign();
        int lat, l1c; bit bok;
        set_out(0, 32'hBF800000); set_out(1, 32'h80000000); set_out(2, 32'h3F800000);
        set_out(3, 32'h3F000000); set_out(4, 32'h00000000); set_out(5, 32'h3F7FFFFF);
        set_out(6, 32'hBF800000); set_out(7, 32'h3F800000); set_out(8, 32'h3E800000);
        set_out(9, 32'hC0000000);
        run(2, 1'b0, lat, l1c, bok); tick();
        expect_result("tie", lat, 15, 4'd2, 32'h3F800000);
        fill(32'hBF000000);
        set_out(5, 32'hBDCCCCCD);
        run(4, 1'b0, lat, l1c, bok); tick();
        expect_result("all_neg", lat, 17, 4'd5, 32'hBDCCCCCD);
        fill(32'h3F800000);
        set_out(9, 32'h40000000);
        run(1, 1'b0, lat, l1c, bok); tick();
        expect_result("last_idx", lat, 14, 4'd9, 32'h40000000);
    endtask

    task automatic test_nan_zero();
        int lat, l1c; bit bok;
        fill(32'hC0000000);
        set_out(0, 32'h7FC00000); set_out(1, 32'h80000000);
        run(3, 1'b0, lat, l1c, bok); tick();
        expect_result("nan_first", lat, 16, 4'd1, 32'h80000000);
        for (int i = 0; i < OUT_SIZE; i++) set_out(i, (i % 2 == 1) ? 32'h80000000 : 32'h00000000);
        set_out(0, 32'h80000000);
        run(3, 1'b0, lat, l1c, bok); tick();
        expect_result("zeros", lat, 16, 4'd0, 32'h80000000);
        fill(32'h3F800000);
        set_out(0, 32'hFF800000); set_out(4, 32'h7F800000);
        set_out(6, 32'h7FC00001); set_out(9, 32'h7FFFFFFF);
        run(3, 1'b0, lat, l1c, bok); tick();
        expect_result("inf_nan", lat, 16, 4'd4, 32'h7F800000);
    endtask

    task automatic test_timeout();
        int lat, l1c; bit bok;
        fill(32'h3F800000);
        run(-1, 1'b0, lat, l1c, bok);
        expect_result("timeout", lat, 51, 4'd0, 32'h0);
        total++; if (bus.error !== 1'b1) $display("FAIL timeout_error: got %b expected 1", bus.error); else passed++;
        tick();
        total++; if (bus.error !== 1'b1) $display("FAIL timeout_error_held: got %b expected 1", bus.error); else passed++;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++; if (bus.error !== 1'b0) $display("FAIL timeout_error_clear: got %b expected 0", bus.error); else passed++;
        // Let this run finish normally: l1_done in cycle 5 after l1_start.
        lat = -1;
        for (int j = 0; j < 300; j++) begin
            bus.l1_done = (j == 5);
            if (bus.done) begin lat = j; break; end
            tick();
        end
        bus.l1_done = 1'b0;
        set_out(6, 32'h40400000);
        total++; if (lat != 18) $display("FAIL recover_latency: got %0d expected 18", lat); else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        int l1c = 0, dnc = 0, last = 0;
        int ls_pos[3] = '{-1, -1, -1};
        int dn_pos[3] = '{-1, -1, -1};
        fill(32'h3DCCCCCD);
        set_out(8, 32'h3F000000);
        bus.start = 1'b1;
        tick();
        for (int j = 0; j < 54; j++) begin
            if (bus.l1_start) begin
                if (l1c < 3) ls_pos[l1c] = j;
                l1c++; last = j;
            end
            if (bus.done) begin
                if (dnc < 3) dn_pos[dnc] = j;
                dnc++;
            end
            bus.l1_done = ((j - last) == 3);
            if (j == 53) bus.start = 1'b0;
            tick();
        end
        bus.l1_done = 1'b0;
        total++; if (l1c != 3) $display("FAIL b2b_l1_start_count: got %0d expected 3", l1c); else passed++;
        total++; if (dnc != 3) $display("FAIL b2b_done_count: got %0d expected 3", dnc); else passed++;
        total++; if (dn_pos[0] != 16) $display("FAIL b2b_first_done: got %0d expected 16", dn_pos[0]); else passed++;
        total++; if (ls_pos[1] != 18) $display("FAIL b2b_restart: got %0d expected 18", ls_pos[1]); else passed++;
        total++; if (bus.class_idx !== 4'd8) $display("FAIL b2b_idx: got %0d expected 8", bus.class_idx); else passed++;
        tick();
        total++; if (bus.busy !== 1'b0) $display("FAIL b2b_idle: got %b expected 0", bus.busy); else passed++;
    endtask

    task automatic test_l1_done_held();
        int lat, l1c; bit bok;
        fill(32'h3DCCCCCD);
        set_out(1, 32'h3F666666);
        bus.l1_done = 1'b1;
        tick();
        run(0, 1'b1, lat, l1c, bok);
        expect_result("held_done", lat, 14, 4'd1, 32'h3F666666);
        tick();
    endtask

    task automatic test_reset_mid();
        int lat, l1c; bit bok; bit done_seen = 1'b0;
        fill(32'h3DCCCCCD);
        set_out(7, 32'h3F666666);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int j = 0; j < 7; j++) begin
            bus.l1_done = (j == 2);
            tick();
        end
        bus.l1_done = 1'b0;
        total++; if (bus.busy !== 1'b1) $display("FAIL mid_busy_before: got %b expected 1", bus.busy); else passed++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++; if ({bus.busy, bus.done, bus.error, bus.l1_start} !== 4'b0000)
            $display("FAIL mid_reset_ctrl: got %b expected 0000", {bus.busy, bus.done, bus.error, bus.l1_start}); else passed++;
        total++; if ({bus.class_idx, bus.class_val} !== 36'h0)
            $display("FAIL mid_reset_result: got %0d/%h expected 0/0", bus.class_idx, bus.class_val); else passed++;
        for (int j = 0; j < 20; j++) begin
            if (bus.done) done_seen = 1'b1;
            tick();
        end
        total++; if (done_seen !== 1'b0) $display("FAIL mid_no_done: got %b expected 0", done_seen); else passed++;
        run(2, 1'b0, lat, l1c, bok); tick();
        expect_result("after_reset", lat, 15, 4'd7, 32'h3F666666);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.l1_done   = 1'b0;
        bus.l2_result = '0;
        tick(); tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_basic();
        test_tie_sign();
        test_nan_zero();
        test_timeout();
        test_back_to_back();
        test_l1_done_held();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
